vram_arbiter: RTL and testbench

- Shares one single-port synchronous pixel RAM between two requesters: the display fetch path (scan-out reads) and a drawing/host writer.
- Priority window is derived from the 11-bit sync-generator counters (1280x1024 timing, 1688x1066 total):
  - Display has absolute priority in the prefetch-extended active area.
  - Writer has priority in blanking.
- Sits between the sync generator and the frame-buffer RAM.

---
 rtl/vram_pkg.sv | 51 +++++
 rtl/vram_arbiter_if.sv | 52 +++++
 rtl/vram_prio_window.sv | 67 ++++++
 rtl/vram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VRAM arbiter slice.
//   - 1280x1024 raster timing constants (1688 x 1066 total), expressed in the
//     sync generator's CounterX / CounterY coordinates.
//   - Arbiter state encoding (write-priority / display-priority).
//   - A small inclusive range-compare helper used by the priority window.
// No ports (package).
// -----------------------------------------------------------------------------
package vram_pkg;

    // Width of the sync generator's position counters.
    localparam int CNT_W = 11;

    // Raster totals (counter wraps at H_TOTAL-1 / V_TOTAL-1).
    localparam int H_TOTAL = 1688;
    localparam int V_TOTAL = 1066;

    // Active-area bounds, inclusive.
    localparam int DEF_H_ACT_START = 360;
    localparam int DEF_H_ACT_END   = 1639;
    localparam int DEF_V_ACT_START = 41;
    localparam int DEF_V_ACT_END   = 1064;

    // Display priority begins this many pixels before the first active pixel
    // so the scan-out FIFO can be primed ahead of the visible line.
    localparam int DEF_PREFETCH = 4;

    // Default RAM geometry.
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 32;

    // State encoding.
    localparam logic ST_WR_PRI   = 1'b0;
    localparam logic ST_DISP_PRI = 1'b1;

    typedef enum logic {
        WR_PRI   = ST_WR_PRI,
        DISP_PRI = ST_DISP_PRI
    } arb_state_e;

    // Inclusive range test on a raster counter value.
    function automatic logic in_range(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage : vram_pkg

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the request/response and RAM-side signals of the VRAM arbiter.
//   Display read port : disp_req, disp_addr -> disp_rvalid, disp_rdata
//   Writer port       : wr_valid, wr_addr, wr_data -> wr_ready
//   RAM port          : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter's view (drives responses and the RAM port)
//   master - the surrounding system's view (requesters plus the RAM model)
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    // Display fetch path
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    // Drawing / host writer
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    // Single-port synchronous RAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_rvalid, disp_rdata,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_rvalid, disp_rdata,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : vram_arbiter_if

// File: rtl/vram_prio_window.sv
// -----------------------------------------------------------------------------
// vram_prio_window
// Priority-window FSM. Each cycle the state register is loaded with whether
// the raster position lies inside the prefetch-extended active area:
//   y in [V_ACT_START, V_ACT_END] and x in [H_ACT_START-PREFETCH, H_ACT_END]
// so a transition becomes visible the cycle after the counters cross a bound.
// Ports:
//   clk, rst            clock, synchronous active-high reset (-> WR_PRI)
//   counter_x/counter_y raster position from the sync generator
//   state               current arbitration state (WR_PRI / DISP_PRI)
// PREFETCH must be smaller than H_ACT_START.
// -----------------------------------------------------------------------------
module vram_prio_window
    import vram_pkg::*;
#(
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_END   = DEF_H_ACT_END,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_END   = DEF_V_ACT_END,
    parameter int PREFETCH    = DEF_PREFETCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter_x,
    input  logic [CNT_W-1:0] counter_y,
    output arb_state_e       state
);

    // axis_in[0]: horizontal inside, axis_in[1]: vertical inside
    logic [1:0] axis_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [CNT_W-1:0] LO = (gi == 0) ? CNT_W'(H_ACT_START - PREFETCH)
                                                        : CNT_W'(V_ACT_START);
            localparam logic [CNT_W-1:0] HI = (gi == 0) ? CNT_W'(H_ACT_END)
                                                        : CNT_W'(V_ACT_END);
            logic [CNT_W-1:0] pos;
            assign pos         = (gi == 0) ? counter_x : counter_y;
            assign axis_in[gi] = in_range(pos, LO, HI);
        end
    endgenerate

    arb_state_e state_q;
    arb_state_e state_d;

    // The window is a pure function of the current position; no hysteresis,
    // so counter wrap-around needs no special casing.
    always_comb begin
        state_d = WR_PRI;
        if (&axis_in) begin
            state_d = DISP_PRI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_PRI;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule : vram_prio_window

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous pixel RAM between the display fetch path
// and a drawing/host writer. Inside the prefetch-extended active area the
// display has absolute priority; in blanking the writer wins. A display
// request that loses is dropped (not queued).
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   counter_x, counter_y  raster position from the sync generator (11 bit)
//   bus (slave)           display read port, writer port, RAM port
//   disp_pri              1 while in the display-priority state
//   wr_stall_cnt          (only with VRAM_ARB_STATS_EN) per-frame count of
//                         cycles the writer was stalled, saturating
// Read latency: request accepted in cycle t -> mem_en in t+1, RAM data in
// t+2, disp_rvalid/disp_rdata in t+3. Fully pipelined.
// Optional feature macro: VRAM_ARB_STATS_EN
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_END   = DEF_H_ACT_END,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_END   = DEF_V_ACT_END,
    parameter int PREFETCH    = DEF_PREFETCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter_x,
    input  logic [CNT_W-1:0] counter_y,
    vram_arbiter_if.slave    bus,
    output logic             disp_pri
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]      wr_stall_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Priority window
    // -------------------------------------------------------------------------
    arb_state_e state;

    vram_prio_window #(
        .H_ACT_START (H_ACT_START),
        .H_ACT_END   (H_ACT_END),
        .V_ACT_START (V_ACT_START),
        .V_ACT_END   (V_ACT_END),
        .PREFETCH    (PREFETCH)
    ) u_prio_window (
        .clk       (clk),
        .rst       (rst),
        .counter_x (counter_x),
        .counter_y (counter_y),
        .state     (state)
    );

    assign disp_pri = (state == DISP_PRI);

    // -------------------------------------------------------------------------
    // Combinational arbitration
    // -------------------------------------------------------------------------
    logic disp_win;
    logic wr_win;

    always_comb begin
        disp_win = 1'b0;
        wr_win   = 1'b0;
        // Nobody is granted while in reset so wr_ready never signals a
        // transfer that the reset would then swallow.
        if (!rst) begin
            case (state)
                DISP_PRI: begin
                    disp_win = bus.disp_req;
                    wr_win   = bus.wr_valid && !bus.disp_req;
                end
                default: begin
                    wr_win   = bus.wr_valid;
                    disp_win = bus.disp_req && !bus.wr_valid;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_win;

    // -------------------------------------------------------------------------
    // RAM drive and read-return pipeline
    // -------------------------------------------------------------------------
    logic              mem_en_q,      mem_en_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    // rd_pend: a display read is on the RAM port this cycle.
    // rd_data: that read's data is on mem_rdata this cycle.
    logic              rd_pend_q,     rd_pend_d;
    logic              rd_data_q,     rd_data_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q,  disp_rdata_d;

    always_comb begin
        mem_en_d      = disp_win | wr_win;
        mem_we_d      = wr_win;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rd_pend_d     = disp_win && !wr_win;
        rd_data_d     = rd_pend_q;
        disp_rvalid_d = rd_data_q;
        disp_rdata_d  = disp_rdata_q;

        if (wr_win) begin
            mem_addr_d  = bus.wr_addr;
            mem_wdata_d = bus.wr_data;
        end else if (disp_win) begin
            mem_addr_d  = bus.disp_addr;
        end

        if (rd_data_q) begin
            disp_rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_data_q     <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
        end else begin
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_pend_q     <= rd_pend_d;
            rd_data_q     <= rd_data_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Writer stall statistics, cleared once per frame at raster (0,0)
    // -------------------------------------------------------------------------
    logic [15:0] wr_stall_cnt_q, wr_stall_cnt_d;

    always_comb begin
        wr_stall_cnt_d = wr_stall_cnt_q;
        if ((counter_x == '0) && (counter_y == '0)) begin
            wr_stall_cnt_d = '0;
        end else if (bus.wr_valid && !wr_win && (wr_stall_cnt_q != 16'hFFFF)) begin
            wr_stall_cnt_d = wr_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stall_cnt_q <= '0;
        end else begin
            wr_stall_cnt_q <= wr_stall_cnt_d;
        end
    end

    assign wr_stall_cnt = wr_stall_cnt_q;
`endif

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter: drives the raster counters and both
// requesters directly and models the single-port synchronous RAM.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cx;
    logic [10:0] cy;
    logic        disp_pri;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] wr_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(17), .DATA_W(32)) bus ();

    vram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .counter_x    (cx),
        .counter_y    (cy),
        .bus          (bus),
        .disp_pri     (disp_pri)
`ifdef VRAM_ARB_STATS_EN
        ,
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    // Small RAM model indexed by the low address bits; registered read.
    logic [31:0] ram [0:511];
    logic [31:0] ram_rdata = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
            end else begin
                ram_rdata <= ram[bus.mem_addr[8:0]];
            end
        end
    end

    assign bus.mem_rdata = ram_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // RAM preload
        ram[9'h010] <= 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            ram[9'h100 + 9'(i)] <= 32'hA500_0000 + 32'(i);
        end

        // ---------------- Reset with both requesters active ----------------
        rst           = 1'b1;
        cx            = 11'd0;
        cy            = 11'd0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00010;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 17'h00055;
        bus.wr_data   = 32'hCAFE0000;
        repeat (3) tick();
        check("rst_wr_ready",  64'(bus.wr_ready),    64'd0);
        check("rst_mem_en",    64'(bus.mem_en),      64'd0);
        check("rst_mem_we",    64'(bus.mem_we),      64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),    64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata),   64'd0);
        check("rst_rvalid",    64'(bus.disp_rvalid), 64'd0);
        check("rst_rdata",     64'(bus.disp_rdata),  64'd0);
        check("rst_disp_pri",  64'(disp_pri),        64'd0);
        $display("[TB] reset: held 3 cycles with both requesters, outputs cleared");

        rst          = 1'b0;
        bus.disp_req = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        check("post_rst_disp_pri", 64'(disp_pri),   64'd0);
        check("post_rst_mem_en",   64'(bus.mem_en), 64'd0);

        // ---------------- Window entry / exit ----------------
        cy = 11'd100;
        cx = 11'd354;  tick(); check("win_x354",  64'(disp_pri), 64'd0);
        cx = 11'd355;  tick(); check("win_x355",  64'(disp_pri), 64'd0);
        cx = 11'd356;  tick(); check("win_x356",  64'(disp_pri), 64'd1);
        cx = 11'd357;  tick(); check("win_x357",  64'(disp_pri), 64'd1);
        cx = 11'd1639; tick(); check("win_x1639", 64'(disp_pri), 64'd1);
        cx = 11'd1640; tick(); check("win_x1640", 64'(disp_pri), 64'd0);
        cx = 11'd500;
        cy = 11'd1064; tick(); check("win_y1064", 64'(disp_pri), 64'd1);
        cy = 11'd1065; tick(); check("win_y1065", 64'(disp_pri), 64'd0);
        cy = 11'd41;   tick(); check("win_y41",   64'(disp_pri), 64'd1);
        cy = 11'd40;   tick(); check("win_y40",   64'(disp_pri), 64'd0);
        cx = 11'd0; cy = 11'd0; tick(); check("win_wrap", 64'(disp_pri), 64'd0);
        cx = 11'd500; cy = 11'd100; tick(); check("win_mid", 64'(disp_pri), 64'd1);
        $display("[TB] window: sweep done, rise after x=356, fall after x=1640");

        // ---------------- Display priority, simultaneous requests ----------------
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00010;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 17'h00055;
        bus.wr_data   = 32'h11112222;
        #1;
        check("dp_wr_ready", 64'(bus.wr_ready), 64'd0);
        tick();   // t+1
        bus.disp_req = 1'b0;
        bus.wr_valid = 1'b0;
        check("dp_mem_en",    64'(bus.mem_en),    64'd1);
        check("dp_mem_we",    64'(bus.mem_we),    64'd0);
        check("dp_mem_addr",  64'(bus.mem_addr),  64'h10);
        check("dp_wdata_hld", 64'(bus.mem_wdata), 64'd0);
        tick();   // t+2
        check("dp_rvalid_t2", 64'(bus.disp_rvalid), 64'd0);
        tick();   // t+3
        check("dp_rvalid_t3", 64'(bus.disp_rvalid), 64'd1);
        check("dp_rdata_t3",  64'(bus.disp_rdata),  64'hDEADBEEF);
        tick();   // t+4
        check("dp_rvalid_t4", 64'(bus.disp_rvalid), 64'd0);
        check("dp_rdata_hld", 64'(bus.disp_rdata),  64'hDEADBEEF);
        check("dp_mem_en_t4", 64'(bus.mem_en),      64'd0);
        $display("[TB] display-priority read addr 0x10 -> 0x%08h", bus.disp_rdata);

        // Writer alone during display priority still gets through.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 17'h00033;
        bus.wr_data  = 32'h0BADF00D;
        #1;
        check("dpw_wr_ready", 64'(bus.wr_ready), 64'd1);
        tick();
        bus.wr_valid = 1'b0;
        check("dpw_mem_we",    64'(bus.mem_we),    64'd1);
        check("dpw_mem_addr",  64'(bus.mem_addr),  64'h33);
        check("dpw_mem_wdata", 64'(bus.mem_wdata), 64'h0BADF00D);
        $display("[TB] lone write in display priority accepted");

        // ---------------- Writer priority ----------------
        cy = 11'd5;
        tick();
        check("wp_disp_pri", 64'(disp_pri), 64'd0);
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 17'h1FFFF;
        bus.wr_data   = 32'h12345678;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00020;
        #1;
        check("wp_wr_ready", 64'(bus.wr_ready), 64'd1);
        tick();
        bus.wr_valid = 1'b0;
        bus.disp_req = 1'b0;
        check("wp_mem_en",    64'(bus.mem_en),    64'd1);
        check("wp_mem_we",    64'(bus.mem_we),    64'd1);
        check("wp_mem_addr",  64'(bus.mem_addr),  64'h1FFFF);
        check("wp_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wp_no_rvalid", 64'(bus.disp_rvalid), 64'd0);
        end
        $display("[TB] writer-priority write addr 0x1FFFF data 0x12345678, display dropped");

        // Lone display read in writer priority wins and reads back the write.
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h1FFFF;
        tick();
        bus.disp_req = 1'b0;
        check("wpr_mem_en",   64'(bus.mem_en),   64'd1);
        check("wpr_mem_we",   64'(bus.mem_we),   64'd0);
        check("wpr_mem_addr", 64'(bus.mem_addr), 64'h1FFFF);
        tick();
        tick();
        check("wpr_rvalid", 64'(bus.disp_rvalid), 64'd1);
        check("wpr_rdata",  64'(bus.disp_rdata),  64'h12345678);
        $display("[TB] lone display read in writer priority -> 0x%08h", bus.disp_rdata);

        // ---------------- Streaming 8 reads ----------------
        cy = 11'd100;
        tick();
        for (int c = 0; c < 12; c++) begin
            bus.disp_req  = (c < 8);
            bus.disp_addr = 17'h00100 + 17'(c);
            check("st_rvalid", 64'(bus.disp_rvalid), 64'((c >= 3) && (c <= 10)));
            if ((c >= 3) && (c <= 10)) begin
                check("st_rdata", 64'(bus.disp_rdata), 64'(32'hA500_0000 + 32'(c - 3)));
            end
            tick();
        end
        bus.disp_req = 1'b0;
        $display("[TB] streaming: 8 back-to-back reads from 0x100");

        // ---------------- Reset mid-operation ----------------
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00010;
        tick();
        bus.disp_req = 1'b0;
        rst          = 1'b1;
        bus.wr_valid = 1'b1;
        #1;
        check("mr_wr_ready", 64'(bus.wr_ready), 64'd0);
        tick();
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        check("mr_disp_pri", 64'(disp_pri),   64'd0);
        check("mr_mem_en",   64'(bus.mem_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("mr_no_rvalid", 64'(bus.disp_rvalid), 64'd0);
            tick();
        end
        check("mr_disp_pri_back", 64'(disp_pri), 64'd1);
        $display("[TB] reset mid-read: in-flight read discarded");

`ifdef VRAM_ARB_STATS_EN
        // ---------------- Writer stall statistics ----------------
        cx = 11'd0; cy = 11'd0;
        tick();
        check("stat_clear0", 64'(wr_stall_cnt), 64'd0);
        cx = 11'd500; cy = 11'd100;
        tick();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00010;
        bus.wr_valid  = 1'b1;
        repeat (20) tick();
        bus.disp_req = 1'b0;
        bus.wr_valid = 1'b0;
        check("stat_cnt20", 64'(wr_stall_cnt), 64'd20);
        tick();
        check("stat_hold20", 64'(wr_stall_cnt), 64'd20);
        cx = 11'd0; cy = 11'd0;
        tick();
        check("stat_frame_clr", 64'(wr_stall_cnt), 64'd0);
        $display("[TB] stats: 20 stalled cycles counted, cleared at frame start");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vram_arbiter
